// File: rtl/bp_fe_instr_queue_pkg.sv
// Shared types and constants for the FE instruction queue.
package bp_fe_instr_queue_pkg;

    localparam int vaddr_width_p  = 39;
    localparam int instr_width_gp = 32;
    localparam int fetch_ptr_gp   = 2;

    // One assembled fetch as stored in the queue.
    typedef struct packed {
        logic [vaddr_width_p-1:0]  pc;
        logic [instr_width_gp-1:0] instr;
        logic [fetch_ptr_gp-1:0]   count;
        logic                      partial;
    } bp_fe_instr_queue_entry_s;

    // RVC encodings never have both low opcode bits set.
    function automatic logic is_compressed(input logic [instr_width_gp-1:0] instr);
        return ~&instr[1:0];
    endfunction

endpackage

// File: rtl/bp_fe_instr_queue_ptr.sv
// Wrapping queue pointer with synchronous clear; used for both read and write sides.
module bp_fe_instr_queue_ptr #(
    parameter int els_p = 4,
    localparam int ptr_w = $clog2(els_p)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [ptr_w-1:0] ptr_o
);

    logic [ptr_w-1:0] ptr_reg;

    // Depth is a power of two, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            ptr_reg <= '0;
        end else if (inc_i) begin
            ptr_reg <= ptr_reg + ptr_w'(1);
        end
    end

    assign ptr_o = ptr_reg;

endmodule

// File: rtl/bp_fe_instr_queue.sv
// Decoupling FIFO between the fetch realigner and instruction issue.
module bp_fe_instr_queue
    import bp_fe_instr_queue_pkg::*;
#(
    parameter int els_p = 4,
    localparam int ptr_w = $clog2(els_p),
    localparam int cnt_w = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      redirect_v_i,
    input  logic                      fetch_instr_v_i,
    input  logic [vaddr_width_p-1:0]  fetch_pc_i,
    input  logic [instr_width_gp-1:0] fetch_instr_i,
    input  logic [fetch_ptr_gp-1:0]   fetch_count_i,
    input  logic                      fetch_partial_i,
    output logic                      fetch_ready_then_o,
    output logic                      issue_v_o,
    output logic [vaddr_width_p-1:0]  issue_pc_o,
    output logic [instr_width_gp-1:0] issue_instr_o,
    output logic                      issue_compressed_o,
    output logic                      issue_partial_o,
    output logic [fetch_ptr_gp-1:0]   issue_count_o,
    input  logic                      issue_yumi_i,
    output logic [cnt_w-1:0]          occupancy_o
);

    logic                     enq;
    logic                     deq;
    logic                     full;
    logic                     empty;
    logic                     flush;
    logic [cnt_w-1:0]         cnt_reg;
    logic [cnt_w-1:0]         cnt_next;
    logic [1:0]               ptr_inc;
    logic [ptr_w-1:0]         ptr_val [2];
    logic [ptr_w-1:0]         rptr;
    logic [ptr_w-1:0]         wptr;
    bp_fe_instr_queue_entry_s wr_entry;
    bp_fe_instr_queue_entry_s head;
    bp_fe_instr_queue_entry_s mem [els_p];

    // A redirect discards everything, including anything arriving this cycle.
    assign flush = redirect_v_i;
    assign enq   = fetch_instr_v_i & ~redirect_v_i;
    assign deq   = issue_yumi_i & ~redirect_v_i;

    assign full  = (cnt_reg == cnt_w'(els_p));
    assign empty = (cnt_reg == '0);

    // Index 0 is the read pointer, index 1 the write pointer.
    assign ptr_inc = {enq, deq};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ptr
            bp_fe_instr_queue_ptr #(.els_p(els_p)) u_ptr (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .clear_i (flush),
                .inc_i   (ptr_inc[gi]),
                .ptr_o   (ptr_val[gi])
            );
        end
    endgenerate

    assign rptr = ptr_val[0];
    assign wptr = ptr_val[1];

    // Occupancy moves by +1/-1/0 depending on which sides are active.
    always_comb begin
        cnt_next = cnt_reg;
        case ({enq, deq})
            2'b10:   cnt_next = cnt_reg + cnt_w'(1);
            2'b01:   cnt_next = cnt_reg - cnt_w'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // Occupancy register; cleared together with the pointers.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign wr_entry = '{pc: fetch_pc_i, instr: fetch_instr_i,
                        count: fetch_count_i, partial: fetch_partial_i};

    // Payload storage; not reset, only written on an accepted enqueue.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= wr_entry;
        end
    end

    // Head is read straight out of storage so issue sees it the cycle after the write.
    assign head = mem[rptr];

    assign fetch_ready_then_o = ~full;
    assign issue_v_o          = ~empty;
    assign issue_pc_o         = head.pc;
    assign issue_compressed_o = is_compressed(head.instr);
    assign issue_instr_o      = issue_compressed_o ? {16'h0000, head.instr[15:0]} : head.instr;
    assign issue_partial_o    = head.partial;
    assign issue_count_o      = head.count;
    assign occupancy_o        = cnt_reg;

    // Producer must respect ready; consumer must respect valid.
    a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(fetch_instr_v_i && !redirect_v_i && full));
    a_no_yumi_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(issue_yumi_i && !redirect_v_i && empty));

endmodule
